// File: rtl/fft_test_sys_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fft_test_sys_mem_arbiter
// Brief    : Round-robin two-master arbiter for the shared single-port RAM,
//            with a one-cycle fixed-latency read return path per master.
// Revision : 1.0 - initial release
// ============================================================================
module fft_test_sys_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    logic       w_req0;
    logic       w_req1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       r_last_grant;
    logic [1:0] r_rd_pend;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // On a tie the master that did not win last time is served.
    assign w_gnt0 = ~reset & ~freeze & w_req0 & (~w_req1 | (r_last_grant == c_M1));
    assign w_gnt1 = ~reset & ~freeze & w_req1 & (~w_req0 | (r_last_grant == c_M0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= c_M1;
            r_rd_pend    <= 2'b00;
        end else begin
            if (w_gnt0) begin
                r_last_grant <= c_M0;
            end else if (w_gnt1) begin
                r_last_grant <= c_M1;
            end
            // Read+write together counts as a write, so no read response.
            r_rd_pend[0] <= w_gnt0 & ~m0_write;
            r_rd_pend[1] <= w_gnt1 & ~m1_write;
        end
    end

    assign m0_waitrequest = ~w_gnt0;
    assign m1_waitrequest = ~w_gnt1;

    assign ram_chipselect = w_gnt0 | w_gnt1;
    assign ram_write      = w_gnt1 ? m1_write      : (w_gnt0 & m0_write);
    assign ram_address    = w_gnt1 ? m1_address    : m0_address;
    assign ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
    assign ram_clken      = 1'b1;

    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;

    // A pending return is dropped if reset arrives in its delivery cycle.
    assign m0_readdatavalid = r_rd_pend[0] & ~reset;
    assign m1_readdatavalid = r_rd_pend[1] & ~reset;

endmodule
`default_nettype wire
